l15_data_ram_banked: RTL and testbench

//  Next-gen L1.5 icache data store: NB_BANKS word-interleaved flop banks with byte-enable writes.
//  Two ports: a refill write port (from the L2 refill FSM) and a fetch read port (to L1 prefetch).

---
 rtl/l15_data_ram_pkg.sv | 24 ++
 rtl/l15_data_ram_bank.sv | 54 +++++
 rtl/l15_data_ram_banked.sv | 110 +++++++++++
 tb/tb_l15_data_ram_banked.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/l15_data_ram_pkg.sv
// Shared types and helpers for the banked L1.5 icache data store.
// Bank/word address split, arbitration outcome encoding and byte parity.
package l15_data_ram_pkg;

  typedef enum logic [1:0] {
    ARB_NONE,
    ARB_WR,
    ARB_RD
  } arb_e;

  function automatic int unsigned bank_idx(input int unsigned addr, input int unsigned nb_banks);
    return addr % nb_banks;
  endfunction

  function automatic int unsigned bank_word(input int unsigned addr, input int unsigned nb_banks);
    return addr / nb_banks;
  endfunction

  // Even parity: stored bit makes the byte plus parity bit have an even count of ones.
  function automatic logic even_par(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/l15_data_ram_bank.sv
// One flop bank: byte-enable write, registered read that holds until the next read.
// Parity storage present only when L15_DATA_RAM_PARITY_EN is defined.
module l15_data_ram_bank #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned WORD_AW    = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [WORD_AW-1:0]      waddr,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [DATA_WIDTH-1:0]   wdata,
`ifdef L15_DATA_RAM_PARITY_EN
  input  logic [DATA_WIDTH/8-1:0] wpar,
  output logic [DATA_WIDTH/8-1:0] rpar,
`endif
  input  logic                    re,
  input  logic [WORD_AW-1:0]      raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic [DATA_WIDTH-1:0] mem [2**WORD_AW];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < DATA_WIDTH/8; i++) begin
        if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

`ifdef L15_DATA_RAM_PARITY_EN
  logic [DATA_WIDTH/8-1:0] par_mem [2**WORD_AW];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < DATA_WIDTH/8; i++) begin
        if (be[i]) par_mem[waddr][i] <= wpar[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rpar <= '0;
    else if (re) rpar <= par_mem[raddr];
  end
`endif

endmodule

// File: rtl/l15_data_ram_banked.sv
// Word-interleaved banked L1.5 icache data store with write/read conflict arbitration.
// Optional per-byte parity: define L15_DATA_RAM_PARITY_EN.
module l15_data_ram_banked
  import l15_data_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned NB_BANKS   = 2,
  parameter int unsigned MAX_STALL  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_req_i,
  output logic                    wr_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   wr_addr_i,
  input  logic [DATA_WIDTH/8-1:0] wr_be_i,
  input  logic [DATA_WIDTH-1:0]   wr_wdata_i,
  input  logic                    rd_req_i,
  output logic                    rd_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   rd_addr_i,
  output logic                    rd_rvalid_o,
  output logic [DATA_WIDTH-1:0]   rd_rdata_o,
  output logic                    rd_perr_o
);

  localparam int unsigned BANK_W  = (NB_BANKS > 1) ? $clog2(NB_BANKS) : 1;
  localparam int unsigned WORD_AW = ADDR_WIDTH - $clog2(NB_BANKS);
  localparam int unsigned CNT_W   = $clog2(MAX_STALL + 1);
  localparam int unsigned NBYTES  = DATA_WIDTH / 8;

  logic [BANK_W-1:0]     wr_bank, rd_bank, rd_bank_q;
  logic [WORD_AW-1:0]    wr_word, rd_word;
  logic [CNT_W-1:0]      stall_cnt;
  logic                  stall_sat;
  arb_e                  arb;
  logic [DATA_WIDTH-1:0] bank_rdata [NB_BANKS];

  assign wr_bank   = BANK_W'(bank_idx(32'(wr_addr_i), NB_BANKS));
  assign rd_bank   = BANK_W'(bank_idx(32'(rd_addr_i), NB_BANKS));
  assign wr_word   = WORD_AW'(bank_word(32'(wr_addr_i), NB_BANKS));
  assign rd_word   = WORD_AW'(bank_word(32'(rd_addr_i), NB_BANKS));
  assign stall_sat = (stall_cnt == CNT_W'(MAX_STALL));

  // Writes win conflicts unless the read has been starved MAX_STALL times in a row.
  always_comb begin
    arb = ARB_NONE;
    if (wr_req_i && rd_req_i && (wr_bank == rd_bank)) arb = stall_sat ? ARB_RD : ARB_WR;
    wr_gnt_o = wr_req_i && (arb != ARB_RD);
    rd_gnt_o = rd_req_i && (arb != ARB_WR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt   <= '0;
      rd_rvalid_o <= 1'b0;
      rd_bank_q   <= '0;
    end else begin
      rd_rvalid_o <= rd_gnt_o;
      if (rd_gnt_o) rd_bank_q <= rd_bank;
      if (!rd_req_i || rd_gnt_o) stall_cnt <= '0;
      else if (!stall_sat)       stall_cnt <= stall_cnt + 1'b1;
    end
  end

`ifdef L15_DATA_RAM_PARITY_EN
  logic [NBYTES-1:0] wpar;
  logic [NBYTES-1:0] bank_rpar [NB_BANKS];

  always_comb begin
    wpar = '0;
    for (int unsigned i = 0; i < NBYTES; i++) wpar[i] = even_par(wr_wdata_i[8*i +: 8]);
  end
`endif

  for (genvar b = 0; b < NB_BANKS; b++) begin : g_bank
    l15_data_ram_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .WORD_AW    (WORD_AW)
    ) u_bank (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_gnt_o && (wr_bank == BANK_W'(b))),
      .waddr (wr_word),
      .be    (wr_be_i),
      .wdata (wr_wdata_i),
`ifdef L15_DATA_RAM_PARITY_EN
      .wpar  (wpar),
      .rpar  (bank_rpar[b]),
`endif
      .re    (rd_gnt_o && (rd_bank == BANK_W'(b))),
      .raddr (rd_word),
      .rdata (bank_rdata[b])
    );
  end

  assign rd_rdata_o = bank_rdata[rd_bank_q];

`ifdef L15_DATA_RAM_PARITY_EN
  // Recomputed from the held registers, so the flag holds alongside rd_rdata_o.
  always_comb begin
    rd_perr_o = 1'b0;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (even_par(rd_rdata_o[8*i +: 8]) != bank_rpar[rd_bank_q][i]) rd_perr_o = 1'b1;
    end
  end
`else
  assign rd_perr_o = 1'b0;
`endif

endmodule

// File: tb/tb_l15_data_ram_banked.sv
// Self-checking bench for l15_data_ram_banked: directed table, hand sequences, random vs model.
module tb_l15_data_ram_banked;

  localparam int unsigned DW   = 128;
  localparam int unsigned AW   = 7;
  localparam int unsigned NB   = 2;
  localparam int unsigned MAXS = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            wr_req_i, rd_req_i;
  logic            wr_gnt_o, rd_gnt_o;
  logic [AW-1:0]   wr_addr_i, rd_addr_i;
  logic [DW/8-1:0] wr_be_i;
  logic [DW-1:0]   wr_wdata_i;
  logic            rd_rvalid_o, rd_perr_o;
  logic [DW-1:0]   rd_rdata_o;

  l15_data_ram_banked #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NB_BANKS   (NB),
    .MAX_STALL  (MAXS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_req_i    (wr_req_i),
    .wr_gnt_o    (wr_gnt_o),
    .wr_addr_i   (wr_addr_i),
    .wr_be_i     (wr_be_i),
    .wr_wdata_i  (wr_wdata_i),
    .rd_req_i    (rd_req_i),
    .rd_gnt_o    (rd_gnt_o),
    .rd_addr_i   (rd_addr_i),
    .rd_rvalid_o (rd_rvalid_o),
    .rd_rdata_o  (rd_rdata_o),
    .rd_perr_o   (rd_perr_o)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model: flat word array, consecutive-denial count, last returned word.
  logic [DW-1:0] mem_m [2**AW];
  int unsigned   denied = 0;
  logic [DW-1:0] last_m = '0;

  typedef struct {
    logic          w;
    logic [AW-1:0] wa;
    logic [15:0]   be;
    logic [DW-1:0] wd;
    logic          r;
    logic [AW-1:0] ra;
    logic          e_wg;
    logic          e_rg;
    logic          dchk;
    logic [DW-1:0] e_data;
  } vec_t;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] fill_pat(input logic [AW-1:0] a);
    return {4{32'hC0DE_0000 | 32'(a)}};
  endfunction

  // One clock: drive at negedge, check grants before posedge, check read return after it.
  task automatic cycle(input logic w, input logic [AW-1:0] wa, input logic [15:0] be,
                       input logic [DW-1:0] wd, input logic r, input logic [AW-1:0] ra,
                       input logic tbl, input logic t_wg, input logic t_rg,
                       input logic t_dchk, input logic [DW-1:0] t_data);
    logic conflict, e_wg, e_rg;
    logic [DW-1:0] rdexp;
    wr_req_i = w; wr_addr_i = wa; wr_be_i = be; wr_wdata_i = wd;
    rd_req_i = r; rd_addr_i = ra;
    #1;
    conflict = w && r && ((wa % NB) == (ra % NB));
    e_rg = r && (!conflict || denied == MAXS);
    e_wg = w && !(conflict && denied == MAXS);
    check("wr_gnt", 128'(wr_gnt_o), 128'(e_wg));
    check("rd_gnt", 128'(rd_gnt_o), 128'(e_rg));
    if (tbl) begin
      check("tbl_wr_gnt", 128'(wr_gnt_o), 128'(t_wg));
      check("tbl_rd_gnt", 128'(rd_gnt_o), 128'(t_rg));
    end
    rdexp = mem_m[ra];
    if (e_wg)
      for (int i = 0; i < DW/8; i++) if (be[i]) mem_m[wa][8*i +: 8] = wd[8*i +: 8];
    if (!r || e_rg) denied = 0;
    else if (denied < MAXS) denied++;
    @(posedge clk); #1;
    check("rvalid", 128'(rd_rvalid_o), 128'(e_rg));
    if (e_rg) last_m = rdexp;
    check("rdata", rd_rdata_o, last_m);
    check("perr", 128'(rd_perr_o), 128'(0));
    if (tbl && t_dchk) check("tbl_rdata", rd_rdata_o, t_data);
    @(negedge clk);
  endtask

  vec_t vecs [$];
  logic [DW-1:0] ones_w, ff_w, a5_w, x22, x33, bemix;

  initial begin
    rst_n = 1'b0;
    wr_req_i = 1'b0; rd_req_i = 1'b0; wr_addr_i = '0; rd_addr_i = '0;
    wr_be_i = '0; wr_wdata_i = '0;
    repeat (2) @(negedge clk);
    check("reset_rvalid", 128'(rd_rvalid_o), 128'(0));
    check("reset_rdata", rd_rdata_o, 128'(0));
    check("reset_perr", 128'(rd_perr_o), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    for (int a = 0; a < 2**AW; a++)
      cycle(1'b1, AW'(a), 16'hFFFF, fill_pat(AW'(a)), 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);

    a5_w   = {16{8'hA5}};
    ones_w = {16{8'h11}};
    ff_w   = {16{8'hFF}};
    x22    = {16{8'h22}};
    x33    = {16{8'h33}};
    bemix  = {ones_w[DW-1:8], 8'hFF};
    //               w     wa      be        wd      r     ra      wg    rg    dchk  data
    vecs.push_back('{1'b1, 7'h05, 16'hFFFF, a5_w,   1'b0, 7'h00, 1'b1, 1'b0, 1'b0, '0});
    vecs.push_back('{1'b0, 7'h00, 16'h0000, '0,     1'b1, 7'h05, 1'b0, 1'b1, 1'b1, a5_w});
    vecs.push_back('{1'b1, 7'h09, 16'hFFFF, ones_w, 1'b0, 7'h00, 1'b1, 1'b0, 1'b0, '0});
    vecs.push_back('{1'b1, 7'h09, 16'h0001, ff_w,   1'b0, 7'h00, 1'b1, 1'b0, 1'b0, '0});
    vecs.push_back('{1'b0, 7'h00, 16'h0000, '0,     1'b1, 7'h09, 1'b0, 1'b1, 1'b1, bemix});
    vecs.push_back('{1'b1, 7'h05, 16'h0000, '0,     1'b0, 7'h00, 1'b1, 1'b0, 1'b0, '0});
    vecs.push_back('{1'b0, 7'h00, 16'h0000, '0,     1'b1, 7'h05, 1'b0, 1'b1, 1'b1, a5_w});
    for (int k = 0; k < 3; k++)
      vecs.push_back('{1'b1, 7'h02, 16'hFFFF, x22, 1'b1, 7'h04, 1'b1, 1'b0, 1'b0, '0});
    vecs.push_back('{1'b1, 7'h02, 16'hFFFF, x22, 1'b1, 7'h04, 1'b0, 1'b1, 1'b1, fill_pat(7'h04)});
    vecs.push_back('{1'b1, 7'h02, 16'hFFFF, x33, 1'b1, 7'h03, 1'b1, 1'b1, 1'b1, fill_pat(7'h03)});
    vecs.push_back('{1'b0, 7'h00, 16'h0000, '0,  1'b1, 7'h02, 1'b0, 1'b1, 1'b1, x33});
    // Two denials, then a drop of rd_req_i must restart the starvation count.
    for (int k = 0; k < 2; k++)
      vecs.push_back('{1'b1, 7'h06, 16'hFFFF, x22, 1'b1, 7'h08, 1'b1, 1'b0, 1'b0, '0});
    vecs.push_back('{1'b0, 7'h00, 16'h0000, '0,  1'b0, 7'h08, 1'b0, 1'b0, 1'b0, '0});
    for (int k = 0; k < 3; k++)
      vecs.push_back('{1'b1, 7'h06, 16'hFFFF, x22, 1'b1, 7'h08, 1'b1, 1'b0, 1'b0, '0});
    vecs.push_back('{1'b1, 7'h06, 16'hFFFF, x22, 1'b1, 7'h08, 1'b0, 1'b1, 1'b1, fill_pat(7'h08)});

    foreach (vecs[i])
      cycle(vecs[i].w, vecs[i].wa, vecs[i].be, vecs[i].wd, vecs[i].r, vecs[i].ra,
            1'b1, vecs[i].e_wg, vecs[i].e_rg, vecs[i].dchk, vecs[i].e_data);

    begin
      logic          w, r, prev_r, prev_rg;
      logic [AW-1:0] wa, ra;
      logic [15:0]   be;
      logic [DW-1:0] wd;
      prev_r = 1'b0; prev_rg = 1'b1; ra = '0;
      for (int n = 0; n < 400; n++) begin
        w  = 1'($urandom_range(0, 1));
        wa = AW'($urandom);
        be = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
        wd = {$urandom, $urandom, $urandom, $urandom};
        if (prev_r && !prev_rg && $urandom_range(0, 4) != 0) r = 1'b1;
        else begin
          r  = 1'($urandom_range(0, 1));
          ra = AW'($urandom);
        end
        prev_r  = r;
        prev_rg = r && !(w && ((wa % NB) == (ra % NB)) && denied != MAXS);
        cycle(w, wa, be, wd, r, ra, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      end
    end

    // Reset arriving while a read is in flight cancels its rvalid and clears the data.
    cycle(1'b0, '0, '0, '0, 1'b1, 7'h05, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    wr_req_i = 1'b0; rd_req_i = 1'b1; rd_addr_i = 7'h09;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    check("midreset_rvalid", 128'(rd_rvalid_o), 128'(0));
    check("midreset_rdata", rd_rdata_o, 128'(0));
    check("midreset_perr", 128'(rd_perr_o), 128'(0));
    @(negedge clk);
    rst_n = 1'b1; rd_req_i = 1'b0;
    denied = 0; last_m = '0;
    cycle(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
